// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  // Operation codes, encoded exactly as the instruction funct3 field
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIN,
    FAST
  } state_e;

  localparam logic [XLEN-1:0] DIV_ZERO_Q = '1;
  localparam logic [XLEN-1:0] INT_MIN    = {1'b1, {(XLEN-1){1'b0}}};

  // funct3[2] separates the divide family from the multiply family
  function automatic logic is_div(md_op_e op);
    return op[2];
  endfunction

  // rs1 is treated as signed by MULH, MULHSU, DIV and REM
  function automatic logic a_signed(md_op_e op);
    return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  // rs2 is treated as signed by MULH, DIV and REM
  function automatic logic b_signed(md_op_e op);
    return op inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the execute stage and the mul/div unit.
interface muldiv_sequencer_if;
  import muldiv_pkg::*;

  logic            valid_i;
  logic            ready_o;
  logic [2:0]      op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            flush_i;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;

  // Requester side (execute stage / testbench)
  modport master (
    output valid_i, op_i, a_i, b_i, flush_i,
    input  ready_o, busy_o, valid_o, result_o
  );

  // Unit side
  modport slave (
    input  valid_i, op_i, a_i, b_i, flush_i,
    output ready_o, busy_o, valid_o, result_o
  );

endinterface

// File: rtl/muldiv_datapath.sv
// Iterative shift-add multiplier / restoring divider datapath.
// acc holds {hi, lo}: for multiply {partial product, multiplier},
// for divide {remainder, quotient}. opd holds multiplicand or divisor.
module muldiv_datapath
  import muldiv_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic            prep_i,
  input  logic            step_i,
  input  md_op_e          op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opd_q, opd_d;
  md_op_e            op_q, op_d;
  logic              neg_q, neg_d;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic              commit;
  logic [XLEN-1:0]   rem_sub;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;

  // Per-iteration arithmetic: conditional add for multiply, trial subtract for divide
  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : {(XLEN+1){1'b0}});
    rem_sh  = acc_q[2*XLEN-1:XLEN-1];
    commit  = (rem_sh >= {1'b0, opd_q});
    // When commit is set the true difference is below the divisor, so XLEN bits hold it
    rem_sub = rem_sh[XLEN-1:0] - opd_q;
  end

  // Register next-state: load raw operands, then take magnitudes, then iterate
  always_comb begin
    acc_d = acc_q;
    opd_d = opd_q;
    op_d  = op_q;
    neg_d = neg_q;
    if (load_i) begin
      acc_d = {{XLEN{1'b0}}, a_i};
      opd_d = b_i;
      op_d  = op_i;
      neg_d = 1'b0;
    end else if (prep_i) begin
      if (a_signed(op_q) && acc_q[XLEN-1]) acc_d = {{XLEN{1'b0}}, -acc_q[XLEN-1:0]};
      if (b_signed(op_q) && opd_q[XLEN-1]) opd_d = -opd_q;
      case (op_q)
        MD_MULH, MD_DIV:   neg_d = acc_q[XLEN-1] ^ opd_q[XLEN-1];
        MD_MULHSU, MD_REM: neg_d = acc_q[XLEN-1];
        default:           neg_d = 1'b0;
      endcase
    end else if (step_i) begin
      if (is_div(op_q)) begin
        if (commit) acc_d = {rem_sub, acc_q[XLEN-2:0], 1'b1};
        else        acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end else begin
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
      end
    end
  end

  // Datapath state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      opd_q <= '0;
      op_q  <= MD_MUL;
      neg_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      opd_q <= opd_d;
      op_q  <= op_d;
      neg_q <= neg_d;
    end
  end

  // Sign fixup and selection of product half, quotient or remainder
  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quot_fix = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      MD_MUL:                       result_o = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result_o = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              result_o = quot_fix;
      default:                      result_o = rem_fix;
    endcase
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: handshake, FSM, counter and special-case
// shortcut around muldiv_datapath.
// Build option: define MULDIV_EARLY_EXIT_EN to send multiplies with a zero
// operand down the one-cycle FAST path.
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  muldiv_sequencer_if.slave  bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  fast_q, fast_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             valid_q, valid_d;

  logic             dp_load, dp_prep, dp_step;
  logic [XLEN-1:0]  dp_result;
  md_op_e           op_in;
  logic             accept;
  logic             special;
  logic [XLEN-1:0]  special_res;

  assign op_in  = md_op_e'(bus.op_i);
  assign accept = bus.valid_i && (state_q == IDLE);

  // Detect requests whose result is known without iterating
  always_comb begin
    special     = 1'b0;
    special_res = '0;
    if (is_div(op_in)) begin
      if (bus.b_i == '0) begin
        special     = 1'b1;
        special_res = op_in[1] ? bus.a_i : DIV_ZERO_Q;
      end else if (!op_in[0] && (bus.a_i == INT_MIN) && (bus.b_i == '1)) begin
        special     = 1'b1;
        special_res = op_in[1] ? '0 : INT_MIN;
      end
    end
`ifdef MULDIV_EARLY_EXIT_EN
    else if ((bus.a_i == '0) || (bus.b_i == '0)) begin
      special     = 1'b1;
      special_res = '0;
    end
`else
`endif
  end

  // Next-state, datapath strobes and result capture; flush overrides everything
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fast_d   = fast_q;
    result_d = result_q;
    valid_d  = 1'b0;
    dp_load  = 1'b0;
    dp_prep  = 1'b0;
    dp_step  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          dp_load = 1'b1;
          fast_d  = special_res;
          state_d = special ? FAST : PREP;
        end
      end
      PREP: begin
        dp_prep = 1'b1;
        cnt_d   = CNT_W'(XLEN - 1);
        state_d = CALC;
      end
      CALC: begin
        dp_step = 1'b1;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIN;
      end
      FIN: begin
        result_d = dp_result;
        valid_d  = 1'b1;
        state_d  = IDLE;
      end
      FAST: begin
        result_d = fast_q;
        valid_d  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush_i) begin
      state_d  = IDLE;
      result_d = result_q;
      valid_d  = 1'b0;
      dp_load  = 1'b0;
      dp_prep  = 1'b0;
      dp_step  = 1'b0;
    end
  end

  // Control state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      fast_q   <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fast_q   <= fast_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  muldiv_datapath u_datapath (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load_i   (dp_load),
    .prep_i   (dp_prep),
    .step_i   (dp_step),
    .op_i     (op_in),
    .a_i      (bus.a_i),
    .b_i      (bus.b_i),
    .result_o (dp_result)
  );

  assign bus.ready_o  = (state_q == IDLE);
  assign bus.busy_o   = (state_q != IDLE);
  assign bus.valid_o  = valid_q;
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected result and latency are
// queued at request time and compared when valid_o strobes.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_sequencer_if bus();

  muldiv_sequencer dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int acc_cyc = 0;
  logic [31:0] last_exp = 32'h0;

  typedef struct {
    logic [31:0] res;
    int          lat;
    string       name;
  } exp_t;
  exp_t sb[$];

  // Reference arithmetic from the RV32M definitions
  function automatic logic [31:0] model(md_op_e op, logic [31:0] a, logic [31:0] b);
    logic [63:0] p;
    p = 64'h0;
    case (op)
      MD_MUL:    begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
      MD_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      MD_MULHSU: begin p = {{32{a[31]}}, a} * {32'h0, b}; return p[63:32]; end
      MD_MULHU:  begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      MD_DIV: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return $signed(a) / $signed(b);
      end
      MD_DIVU:   return (b == 0) ? 32'hFFFFFFFF : a / b;
      MD_REM: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(md_op_e op, logic [31:0] a, logic [31:0] b);
    if (op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU}) begin
      if (b == 0) return 1;
      if ((op == MD_DIV || op == MD_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
      return 34;
    end
`ifdef MULDIV_EARLY_EXIT_EN
    if (a == 0 || b == 0) return 1;
`else
`endif
    return 34;
  endfunction

  task automatic start_req(input md_op_e op, input logic [31:0] a, input logic [31:0] b, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.ready_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL start_req: ready_o=%b, required 1", bus.ready_o);
      return;
    end
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
    bus.valid_i = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    acc_cyc     = cyc;
  endtask

  task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input string name);
    bit ok;
    exp_t e;
    start_req(op, a, b, ok);
    if (ok) begin
      e.res  = res;
      e.lat  = exp_lat(op, a, b);
      e.name = name;
      sb.push_back(e);
    end
  endtask

  task automatic collect(input bit chk_busy);
    exp_t e;
    bit   got;
    got = 1'b0;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.valid_o === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (chk_busy) begin
        n_vec++;
        if (bus.ready_o !== 1'b0 || bus.busy_o !== 1'b1) begin
          n_err++;
          $display("FAIL %s ready/busy at cycle %0d: got %b/%b, required 0/1",
                   e.name, cyc - acc_cyc, bus.ready_o, bus.busy_o);
        end
      end
    end
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL %s timeout: no valid_o within 60 cycles, required at cycle %0d", e.name, e.lat);
      return;
    end
    if (bus.result_o !== e.res) begin
      n_err++;
      $display("FAIL %s result: got %h, required %h", e.name, bus.result_o, e.res);
    end
    n_vec++;
    if (cyc - acc_cyc != e.lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d, required %0d", e.name, cyc - acc_cyc, e.lat);
    end
    $display("txn %-10s result=%h latency=%0d", e.name, bus.result_o, cyc - acc_cyc);
    last_exp = e.res;
    @(negedge clk);
    n_vec++;
    if (bus.valid_o !== 1'b0 || bus.result_o !== e.res) begin
      n_err++;
      $display("FAIL %s pulse: valid_o=%b result=%h, required 0 and %h", e.name, bus.valid_o, bus.result_o, e.res);
    end
  endtask

  task automatic check_idle_outputs(input string name, input logic [31:0] res);
    n_vec++;
    if (bus.ready_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0 || bus.result_o !== res) begin
      n_err++;
      $display("FAIL %s: ready/busy/valid/result got %b/%b/%b/%h, required 1/0/0/%h",
               name, bus.ready_o, bus.busy_o, bus.valid_o, bus.result_o, res);
    end
  endtask

  task automatic watch_silent(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.valid_o !== 1'b0) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL %s: valid_o seen %0d times, required 0", name, seen);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_state", 32'h0);
    rst_n = 1'b1;
    last_exp = 32'h0;
  endtask

  task automatic test_mul();
    issue(MD_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, "mul_7x-3");
    collect(1'b1);
    issue(MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max");
    collect(1'b0);
    issue(MD_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "mulh_-1");
    collect(1'b0);
    issue(MD_MULHSU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, "mulhsu");
    collect(1'b0);
  endtask

  task automatic test_div();
    issue(MD_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div_-7/2");
    collect(1'b0);
    issue(MD_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem_-7/2");
    collect(1'b0);
    issue(MD_DIVU, 32'd100, 32'd7, 32'd14, "divu_100/7");
    collect(1'b0);
    issue(MD_REMU, 32'd100, 32'd7, 32'd2, "remu_100/7");
    collect(1'b0);
  endtask

  task automatic test_special();
    issue(MD_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, "divu_by0");
    collect(1'b0);
    issue(MD_REM, 32'd5, 32'd0, 32'd5, "rem_by0");
    collect(1'b0);
    issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
    collect(1'b0);
    issue(MD_REM, 32'h80000000, 32'hFFFFFFFF, 32'h0, "rem_ovf");
    collect(1'b0);
  endtask

  task automatic test_early_exit();
    issue(MD_MUL, 32'd0, 32'h1234, 32'h0, "mul_0x");
    collect(1'b0);
    issue(MD_MULHU, 32'hFFFF, 32'd0, 32'h0, "mulhu_x0");
    collect(1'b0);
  endtask

  task automatic test_flush();
    bit ok;
    start_req(MD_MUL, 32'd3, 32'd4, ok);
    repeat (10) @(negedge clk);
    bus.flush_i = 1'b1;
    @(negedge clk);
    check_idle_outputs("flush_cycle11", last_exp);
    // Request presented together with flush must be ignored
    bus.op_i    = MD_DIVU;
    bus.a_i     = 32'd9;
    bus.b_i     = 32'd3;
    bus.valid_i = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    check_idle_outputs("flush_priority", last_exp);
    watch_silent("flush_no_valid", 40);
    check_idle_outputs("flush_result_held", last_exp);
  endtask

  task automatic test_back_to_back();
    bit   ok;
    bit   got;
    exp_t e;
    exp_t e2;
    got = 1'b0;
    start_req(MD_MUL, 32'h10, 32'h20, ok);
    if (!ok) return;
    e.res = 32'h200; e.lat = 34; e.name = "b2b_first";
    sb.push_back(e);
    bus.op_i    = MD_DIVU;
    bus.a_i     = 32'd100;
    bus.b_i     = 32'd7;
    bus.valid_i = 1'b1;
    e = sb.pop_front();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.valid_o === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!got || bus.result_o !== e.res || cyc - acc_cyc != e.lat || bus.ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL %s: valid=%b result=%h latency=%0d ready=%b, required 1/%h/%0d/1",
               e.name, got, bus.result_o, cyc - acc_cyc, bus.ready_o, e.res, e.lat);
    end
    $display("txn %-10s result=%h latency=%0d", e.name, bus.result_o, cyc - acc_cyc);
    @(negedge clk);
    bus.valid_i = 1'b0;
    acc_cyc     = cyc;
    n_vec++;
    if (bus.ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_accept: ready_o got %b, required 0", bus.ready_o);
    end
    e2.res = 32'd14; e2.lat = 34; e2.name = "b2b_second";
    sb.push_back(e2);
    collect(1'b0);
  endtask

  task automatic test_reset_mid();
    bit ok;
    start_req(MD_DIV, 32'd1000, 32'd3, ok);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("async_reset", 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    last_exp = 32'h0;
    watch_silent("reset_no_valid", 40);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    md_op_e      op;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 24; i++) begin
      op = md_op_e'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      issue(op, a, b, model(op, a, b), $sformatf("rnd%0d_%s", i, op.name()));
      collect(1'b0);
    end
  endtask

  initial begin
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.op_i    = 3'b000;
    bus.a_i     = 32'h0;
    bus.b_i     = 32'h0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_early_exit();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle controller and datapath for the RV32M multiply/divide instructions. It sits beside the single-cycle ALU in the execute stage. It accepts operands plus funct3 through a valid/ready handshake, runs an iterative shift-add multiply or restoring divide, and returns one 32-bit result with a one-cycle valid pulse. The core stalls execute while busy_o is high.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
valid_i  input  1  request valid; sampled only when ready_o=1
ready_o  output  1  unit can accept a request
op_i  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a_i  input  XLEN  rs1 operand
b_i  input  XLEN  rs2 operand
flush_i  input  1  abort in-flight operation (pipeline flush)
busy_o  output  1  operation in flight
valid_o  output  1  one-cycle result strobe
result_o  output  XLEN  result; held stable until next valid_o

Behaviour:
- Clock and reset: one clock clk_i; rst_ni is asynchronous, active-low.
- Reset values: state=IDLE, ready_o=1, busy_o=0, valid_o=0, result_o=0, all internal registers 0.
- Accept: a request is accepted on a rising edge where valid_i&&ready_o. The edge that accepts is cycle 0. op/a/b are latched; later input changes are ignored.
- ready_o=1 only in IDLE. busy_o = !ready_o.
- States:
  - IDLE: on accept, go to FAST if a special case applies, else go to PREP.
  - PREP (1 cycle): take absolute values of signed operands (MULH: both; MULHSU: a only; DIV/REM: both). Record the result-sign flag. Clear the accumulator. Load counter=XLEN-1. Go to CALC.
  - CALC (XLEN cycles): one iteration per cycle.
    - Multiply: 2*XLEN-bit product register; if multiplier LSB=1, add the multiplicand to the upper half; then shift right 1.
    - Divide: shift {rem,quot} left 1; trial-subtract the divisor from rem; if non-negative, commit it and set quotient LSB.
    - Counter decrements; when counter==0, go to FIN.
  - FIN (1 cycle): apply two's-complement sign fixup; select the low (MUL) or high (MULH*) product half, or quotient/remainder. Register result_o, pulse valid_o, go to IDLE.
  - FAST (1 cycle): register the special result, pulse valid_o, go to IDLE.
- Latency: normal path valid_o at cycle XLEN+2 (34). FAST path valid_o at cycle 1. A new request may be accepted on the edge where valid_o rises.
- Signed fixup rules:
  - Quotient negative iff the operand signs differ.
  - Remainder takes the dividend's sign.
  - MULHSU: product negative iff a is negative.
- Special cases (FAST):
  - Divide by zero: DIV/DIVU give all ones; REM/REMU give a.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- flush_i: forces IDLE on the next edge from any state. No valid_o is produced; result_o is unchanged. flush_i has priority over accept in the same cycle, so a request presented with flush_i is not accepted.
- Reset mid-operation: immediate return to reset values; no valid_o.
- Illegal op values: none exist; all 8 encodings are legal.

Optional Feature:
MULDIV_EARLY_EXIT_EN
- Defined: multiply ops with a==0 or b==0 take the FAST path with result 0 (valid_o at cycle 1).
- Undefined: these ops take the full 34-cycle path with the same numeric result.
- Divide timing is identical with or without the macro.

Decomposition:
- Package muldiv_pkg:
  - XLEN default constant.
  - op enum (MD_MUL..MD_REMU, 3 bits, encoded as funct3).
  - State enum (IDLE, PREP, CALC, FIN, FAST).
  - Constants DIV_ZERO_Q (all ones) and INT_MIN (0x80000000).
- Sub-module muldiv_datapath: operand/product/remainder registers, adder/subtractor, shift logic, sign fixup.
  - Controlled by load/step/finish strobes from the FSM in muldiv_sequencer.
  - The FSM, counter, handshake and special-case detection stay in the top.

Test Plan:
- MUL a=7, b=0xFFFFFFFD -> valid_o at cycle 34, result 0xFFFFFFEB; ready_o low on cycles 1-33.
- MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF at cycle 1; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0.
- Start MUL, assert flush_i at cycle 10 -> IDLE and ready_o=1 at cycle 11, no valid_o, result_o unchanged. Back-to-back request accepted the same edge valid_o rises -> second result at +34.
- Deassert rst_ni asynchronously at cycle 20 of a DIV -> outputs return to reset values immediately, no valid_o. With MULDIV_EARLY_EXIT_EN defined, MUL 0*x -> 0 at cycle 1.
